// File: rtl/spi_regfile_ctrl_if.sv
// Pin and bus bundle for spi_regfile_ctrl: SPI pins, register-file port and debug read port.
// The controller uses the master view; the SPI host, register file and debug requester use the slave view.
interface spi_regfile_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_active;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wdata;
    logic              rf_we;
    logic [7:0]        rf_rdata;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [7:0]        dbg_data;

    modport master (
        input  spi_sclk, spi_cs_n, spi_mosi, rf_rdata, dbg_req, dbg_addr,
        output spi_miso, spi_active, rf_addr, rf_wdata, rf_we, dbg_ack, dbg_data
    );

    modport slave (
        output spi_sclk, spi_cs_n, spi_mosi, rf_rdata, dbg_req, dbg_addr,
        input  spi_miso, spi_active, rf_addr, rf_wdata, rf_we, dbg_ack, dbg_data
    );
endinterface

// File: rtl/spi_regfile_ctrl.sv
// SPI mode-0 command sequencer for a register file: oversampled write (0x02) / read (0x03) with
// auto-incrementing address, sharing the single register-file port with a debug read requester.
module spi_regfile_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_regfile_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        ADDR_W_ST = 3'd2,
        ADDR_R_ST = 3'd3,
        WDATA     = 3'd4,
        RDATA     = 3'd5,
        IGNORE    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
    logic                   sclk_prev_r;
    state_t                 state_r, state_s;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             rx_r, tx_r;
    logic [ADDR_W-1:0]      ptr_r, ptr_s;
    logic [ADDR_W-1:0]      rf_addr_r, rf_addr_s;
    logic [7:0]             rf_wdata_r, rf_wdata_s;
    logic                   rf_we_r, rf_we_s;
    logic                   spi_rd_r, spi_rd_s;
    logic                   dbg_rd_r, dbg_rd_s;
    logic                   dbg_ack_r;
    logic [7:0]             dbg_data_r;
    logic                   miso_r;
    logic                   sclk_s, cs_act_s, mosi_s, rise_s, fall_s, byte_done_s;
    logic [7:0]             byte_s;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign cs_act_s    = ~cs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign rise_s      = cs_act_s & sclk_s & ~sclk_prev_r;
    assign fall_s      = cs_act_s & ~sclk_s & sclk_prev_r;
    assign byte_done_s = rise_s & (bit_cnt_r == 3'd7);
    // Byte as it will stand once the current rising edge is shifted in
    assign byte_s      = {rx_r[6:0], mosi_s};

    assign bus.spi_active = cs_act_s;
    assign bus.spi_miso   = miso_r;
    assign bus.rf_addr    = rf_addr_r;
    assign bus.rf_wdata   = rf_wdata_r;
    assign bus.rf_we      = rf_we_r;
    assign bus.dbg_ack    = dbg_ack_r;
    assign bus.dbg_data   = dbg_data_r;

    // Synchronise the SPI pins; chip select idles deasserted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_prev_r <= sclk_s;
        end
    end

    // Transaction state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, pointer and register-file port schedule for the following cycle
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        rf_addr_s  = rf_addr_r;
        rf_wdata_s = rf_wdata_r;
        rf_we_s    = 1'b0;
        spi_rd_s   = 1'b0;
        dbg_rd_s   = 1'b0;
        if (!cs_act_s) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_s = CMD;
                CMD: begin
                    if (byte_done_s) begin
                        case (byte_s)
                            8'h02:   state_s = ADDR_W_ST;
                            8'h03:   state_s = ADDR_R_ST;
                            default: state_s = IGNORE;
                        endcase
                    end else begin
                        state_s = CMD;
                    end
                end
                ADDR_W_ST: begin
                    if (byte_done_s) begin
                        ptr_s   = byte_s[ADDR_W-1:0];
                        state_s = WDATA;
                    end else begin
                        state_s = ADDR_W_ST;
                    end
                end
                ADDR_R_ST: begin
                    if (byte_done_s) begin
                        rf_addr_s = byte_s[ADDR_W-1:0];
                        ptr_s     = byte_s[ADDR_W-1:0] + PTR_ONE;
                        spi_rd_s  = 1'b1;
                        state_s   = RDATA;
                    end else begin
                        state_s = ADDR_R_ST;
                    end
                end
                WDATA: begin
                    if (byte_done_s) begin
                        rf_addr_s  = ptr_r;
                        rf_wdata_s = byte_s;
                        rf_we_s    = 1'b1;
                        ptr_s      = ptr_r + PTR_ONE;
                    end else begin
                        ptr_s = ptr_r;
                    end
                end
                RDATA: begin
                    if (byte_done_s) begin
                        rf_addr_s = ptr_r;
                        spi_rd_s  = 1'b1;
                        ptr_s     = ptr_r + PTR_ONE;
                    end else begin
                        ptr_s = ptr_r;
                    end
                end
                IGNORE:  state_s = IGNORE;
                default: state_s = IDLE;
            endcase
        end
        // SPI accesses own the port; debug reads only take cycles SPI leaves free
        if (!rf_we_s && !spi_rd_s && bus.dbg_req && !dbg_ack_r && !dbg_rd_r) begin
            dbg_rd_s  = 1'b1;
            rf_addr_s = bus.dbg_addr;
        end else begin
            dbg_rd_s  = 1'b0;
        end
    end

    // Shift registers, bit counter, port registers and read-data capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_r  <= 3'd0;
            rx_r       <= 8'h00;
            tx_r       <= 8'h00;
            ptr_r      <= {ADDR_W{1'b0}};
            rf_addr_r  <= {ADDR_W{1'b0}};
            rf_wdata_r <= 8'h00;
            rf_we_r    <= 1'b0;
            spi_rd_r   <= 1'b0;
            dbg_rd_r   <= 1'b0;
            dbg_ack_r  <= 1'b0;
            dbg_data_r <= 8'h00;
            miso_r     <= 1'b0;
        end else begin
            ptr_r      <= ptr_s;
            rf_addr_r  <= rf_addr_s;
            rf_wdata_r <= rf_wdata_s;
            rf_we_r    <= rf_we_s;
            spi_rd_r   <= spi_rd_s;
            dbg_rd_r   <= dbg_rd_s;
            dbg_ack_r  <= dbg_rd_r;
            if (dbg_rd_r) begin
                dbg_data_r <= bus.rf_rdata;
            end
            if (!cs_act_s) begin
                bit_cnt_r <= 3'd0;
                rx_r      <= 8'h00;
            end else if (rise_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                rx_r      <= byte_s;
            end
            // bit_cnt of 0 marks the falling edge closing a byte: keep the freshly loaded MSB
            if (spi_rd_r) begin
                tx_r <= bus.rf_rdata;
            end else if ((state_r == RDATA) && fall_s && (bit_cnt_r != 3'd0)) begin
                tx_r <= {tx_r[6:0], 1'b0};
            end
            miso_r <= (state_r == RDATA) ? tx_r[7] : 1'b0;
        end
    end
endmodule
